i_wr_stream_ctrl: RTL and testbench
===================================

# i_wr_stream_ctrl

Image write-out controller: walks a stored image in SRAM in raster order, issues one-byte SRAM reads, and presents pixels on a valid/ready stream to the output serializer. It owns the column/row sequencing for SRAM image readback. It sits directly between the SRAM read port and the downstream pixel consumer. A 2-entry skid buffer absorbs the fixed 1-cycle SRAM read latency so that backpressure never drops data.

## Interface
- DATA_W, 8, pixel width in bits
- ADDR_W, 16, SRAM address width
- DIM_W, 13, width of image dimension inputs and internal counters
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a frame when in IDLE, ignored otherwise
- abort  in  1  synchronous; kills the frame and flushes the buffer
- base_addr  in  ADDR_W  SRAM address of pixel (0,0); sampled on start
- img_width / img_height  in  DIM_W each  columns / rows; sampled on start
- sram_rd_en  out  1  read strobe
- sram_addr  out  ADDR_W  read address, valid when sram_rd_en is high
- sram_rdata  in  DATA_W  read data, valid exactly 1 cycle after sram_rd_en
- pix_data  out  DATA_W  pixel at buffer head
- pix_eol / pix_eof  out  1 each  pixel is last in its row / last in the frame
- pix_valid  out  1  buffer head holds a pixel
- pix_ready  in  1  consumer accepts the pixel; a transfer occurs when pix_valid && pix_ready
- busy  out  1  a frame is in progress
- frame_done  out  1  one-cycle pulse on the frame's final transfer

## Operation
- **States:**
  - IDLE: waits for start.
  - READ: issues SRAM reads.
  - DRAIN: all reads issued; waits for the buffer to empty.
- **Start:**
  - IDLE + start with width=0 or height=0 → stay IDLE; pulse frame_done the next cycle; issue no reads.
  - IDLE + start otherwise → READ; col=0, row=0, addr=base_addr.
- **Issue rule (READ):** sram_rd_en = (occupancy + inflight − pop) < 2.
  - pop = pix_valid && pix_ready.
  - rd_en is combinationally dependent on pix_ready; this dependency is required for full throughput.
- **Each issued read:**
  - addr increments by 1, modulo 2^ADDR_W; wrap is silent.
  - col increments; on col = width−1, col goes to 0 and row increments.
  - The read's eol/eof tags are computed at issue and travel with it: eol = (col = width−1); eof = eol && (row = height−1).
- **End of issue:** issuing the eof read moves the FSM READ → DRAIN.
- **Buffer write:** the cycle after each rd_en, {sram_rdata, eol, eof} is written to the buffer.
- **Frame completion:** the transfer of the eof pixel pulses frame_done and moves the FSM to IDLE on the same edge.
- **busy:** high in READ and DRAIN.
- **abort:**
  - In any state: next state IDLE; buffer and inflight cleared; no frame_done pulse.
  - The in-flight SRAM return is discarded.
  - abort has priority over start and over a simultaneous eof transfer.
- **start while busy:** ignored.
- **Reset values (rst asserted):** all outputs 0; state IDLE; counters, addr and buffer cleared; takes effect immediately, including mid-frame.

## Timing
- **Latency:** start sampled at edge k:
  - first sram_rd_en in cycle k+1, with sram_addr = base_addr;
  - data captured at the end of cycle k+2;
  - pix_valid high in cycle k+3.
- **Throughput:** 1 pixel/cycle while pix_ready is held high.
- **Backpressure:**
  - pix_ready low with 2 entries held (or 1 held + 1 inflight) → sram_rd_en low.
  - pix_data, pix_eol and pix_eof stay stable while pix_valid && !pix_ready.
- **Buffer:** never overflows; occupancy + inflight ≤ 2 at all times.
- **Frame length:** with pix_ready always high, a W×H frame completes with frame_done in cycle k+2+W·H.

## Structure
- **Package i_wr_pkg:**
  - state enum typedef (IDLE, READ, DRAIN);
  - DIM_W, ADDR_W and DATA_W defaults;
  - buffer entry struct {data, eol, eof}.
- **Sub-module i_wr_skid_buf:**
  - 2-entry FIFO of entries;
  - ports: push, pop, flush, entry in, head out, occupancy out;
  - same clk/rst.
- **Top level:** FSM, counters and address register live in the top module.

## Test plan
- **Basic 3×2 frame:** base 0x0100, pix_ready=1, SRAM model returns addr[7:0].
  - sram_addr 0x0100..0x0105 on consecutive cycles.
  - Pixels 00..05 delivered, eol on 02 and 05, eof on 05.
  - frame_done in cycle k+8.
- **Backpressure:** 4×1 frame, pix_ready toggled 1,0,0,1,0,1….
  - No pixel lost or duplicated; outputs stable while stalled.
  - occupancy + inflight never exceeds 2.
- **Zero dimension:** start with width=0, height=5.
  - No sram_rd_en; frame_done pulses 1 cycle later; busy stays 0.
- **Address wrap:** base 0xFFFE, 4×1 frame.
  - Addresses FFFE, FFFF, 0000, 0001.
- **Abort / restart:** abort mid-frame with 2 entries buffered.
  - Next cycle: pix_valid=0, busy=0, no frame_done.
  - Immediate restart with a new base reads from the new base.
- **Reset mid-frame:** assert rst asynchronously mid-frame.
  - All outputs go to 0 before the next edge.
  - start after rst deasserts runs a clean frame.

Source files
------------

// File: rtl/i_wr_pkg.sv
// Shared types and default widths for the image write-out controller.
package i_wr_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DIM_W  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  eol;
    logic                  eof;
  } entry_t;
endpackage

// File: rtl/i_wr_stream_ctrl_if.sv
// Control, SRAM read port and pixel stream of the write-out controller.
interface i_wr_stream_ctrl_if #(
  parameter int ADDR_W = i_wr_pkg::DEF_ADDR_W,
  parameter int DATA_W = i_wr_pkg::DEF_DATA_W,
  parameter int DIM_W  = i_wr_pkg::DEF_DIM_W
) ();
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [DIM_W-1:0]  img_width;
  logic [DIM_W-1:0]  img_height;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_eol;
  logic              pix_eof;
  logic              pix_valid;
  logic              pix_ready;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, abort, base_addr, img_width, img_height, sram_rdata, pix_ready,
    output sram_rd_en, sram_addr, pix_data, pix_eol, pix_eof, pix_valid, busy, frame_done
  );

  modport slave (
    output start, abort, base_addr, img_width, img_height, sram_rdata, pix_ready,
    input  sram_rd_en, sram_addr, pix_data, pix_eol, pix_eof, pix_valid, busy, frame_done
  );
endinterface

// File: rtl/i_wr_skid_buf.sv
// Two-entry FIFO holding returned pixels with their row/frame tags.
module i_wr_skid_buf
  import i_wr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     entry_in,
  output entry_t     head,
  output logic [1:0] occupancy
);
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      entry_t slot_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= entry_in;
        end
      end
    end
  endgenerate

  // Flush drops both entries and any return landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  assign head      = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
  assign occupancy = count_reg;
endmodule

// File: rtl/i_wr_stream_ctrl.sv
// Raster-order SRAM readback sequencer feeding a valid/ready pixel stream
// through a two-entry skid buffer that covers the one-cycle read latency.
module i_wr_stream_ctrl
  import i_wr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  i_wr_stream_ctrl_if.master bus
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DIM_W-1:0]  col_reg, row_reg, width_reg, height_reg;
  logic              inflight_reg, inflight_eol_reg, inflight_eof_reg;
  logic              zero_done_reg;

  logic              rd_en, rd_eol, rd_eof, load, zero_start;
  logic              pop, eof_pop;
  logic [2:0]        level;
  logic [DATA_W-1:0] rdata;
  entry_t            entry_in, head;
  logic [1:0]        occupancy;

  assign rdata    = bus.sram_rdata;
  assign entry_in = '{data: rdata, eol: inflight_eol_reg, eof: inflight_eof_reg};
  assign pop      = bus.pix_valid && bus.pix_ready;
  assign eof_pop  = pop && head.eof;
  // Slots that will be committed after this edge; reading only below 2 keeps the buffer from overflowing.
  assign level    = 3'(occupancy) + 3'(inflight_reg) - 3'(pop);
  assign rd_eol   = (col_reg == width_reg - DIM_W'(1));
  assign rd_eof   = rd_eol && (row_reg == height_reg - DIM_W'(1));

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    load       = 1'b0;
    zero_start = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.img_width == '0 || bus.img_height == '0) begin
            zero_start = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = READ;
          end
        end
      end
      READ: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (level < 3'd2) begin
          rd_en = 1'b1;
          if (rd_eof) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort || eof_pop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      col_reg          <= '0;
      row_reg          <= '0;
      width_reg        <= '0;
      height_reg       <= '0;
      inflight_reg     <= 1'b0;
      inflight_eol_reg <= 1'b0;
      inflight_eof_reg <= 1'b0;
      zero_done_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      zero_done_reg    <= zero_start;
      inflight_reg     <= rd_en;
      inflight_eol_reg <= rd_eol;
      inflight_eof_reg <= rd_eof;
      if (load) begin
        addr_reg   <= bus.base_addr;
        col_reg    <= '0;
        row_reg    <= '0;
        width_reg  <= bus.img_width;
        height_reg <= bus.img_height;
      end else if (rd_en) begin
        addr_reg <= addr_reg + ADDR_W'(1);
        if (rd_eol) begin
          col_reg <= '0;
          row_reg <= row_reg + DIM_W'(1);
        end else begin
          col_reg <= col_reg + DIM_W'(1);
        end
      end
    end
  end

  i_wr_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .pop       (pop),
    .flush     (bus.abort),
    .entry_in  (entry_in),
    .head      (head),
    .occupancy (occupancy)
  );

  assign bus.sram_rd_en = rd_en;
  assign bus.sram_addr  = addr_reg;
  assign bus.pix_data   = head.data;
  assign bus.pix_eol    = head.eol;
  assign bus.pix_eof    = head.eof;
  assign bus.pix_valid  = (occupancy != 2'd0);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.frame_done = zero_done_reg || ((state_reg == DRAIN) && eof_pop && !bus.abort);
endmodule

// File: tb/tb_i_wr_stream_ctrl.sv
// Scoreboard bench: expected addresses/pixels are queued at frame start from
// the raster rules, and a negedge monitor checks every read and transfer.
module tb_i_wr_stream_ctrl;
  import i_wr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i_wr_stream_ctrl_if bus ();

  i_wr_stream_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } pix_t;

  pix_t        pix_q[$];
  logic [15:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int zero_cyc = -1;
  int first_rd_cyc = -1;
  int done_cyc = -1;
  int ready_mode = 0;
  int pidx = 0;
  int outstanding = 0;
  bit prev_stall = 0;
  logic [9:0] prev_head;
  bit pattern [6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read returning the low address byte
  always @(posedge clk) if (bus.sram_rd_en) bus.sram_rdata <= bus.sram_addr[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    bus.pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: bus.pix_ready = 1'b1;
        1: bus.pix_ready = 1'($urandom_range(0, 1));
        2: begin bus.pix_ready = pattern[pidx % 6]; pidx++; end
        default: bus.pix_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    bit transfer, exp_done;
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        addr_q.delete();
        pix_q.delete();
        outstanding = 0;
        prev_stall  = 0;
      end else begin
        transfer = bus.pix_valid && bus.pix_ready;
        if (prev_stall)
          chk("stall_stable", {bus.pix_valid, bus.pix_data, bus.pix_eol, bus.pix_eof}, {1'b1, prev_head});
        if (bus.sram_rd_en) begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          if (addr_q.size() == 0) chk("unexpected_read", 1, 0);
          else chk("sram_addr", bus.sram_addr, addr_q.pop_front());
        end
        exp_done = 0;
        if (transfer && !bus.abort) begin
          if (pix_q.size() == 0) chk("unexpected_pixel", 1, 0);
          else begin
            e = pix_q.pop_front();
            chk("pixel", {bus.pix_data, bus.pix_eol, bus.pix_eof}, {e.d, e.eol, e.eof});
            exp_done = e.eof;
          end
        end
        if (zero_cyc == cyc) exp_done = 1;
        if (bus.frame_done || exp_done) begin
          chk("frame_done", bus.frame_done, exp_done);
          if (bus.frame_done) done_cyc = cyc;
        end
        outstanding = outstanding + int'(bus.sram_rd_en) - int'(transfer && !bus.abort);
        if (bus.sram_rd_en) chk("occupancy_le_2", outstanding <= 2, 1);
        if (bus.abort) begin
          addr_q.delete();
          pix_q.delete();
          outstanding = 0;
          prev_stall  = 0;
        end else begin
          prev_stall = bus.pix_valid && !bus.pix_ready;
          prev_head  = {bus.pix_data, bus.pix_eol, bus.pix_eof};
        end
      end
    end
  end

  task automatic start_frame(input logic [15:0] base, input int w, input int h);
    logic [15:0] a;
    bus.base_addr  = base;
    bus.img_width  = 13'(w);
    bus.img_height = 13'(h);
    bus.start      = 1'b1;
    start_cyc      = cyc;
    first_rd_cyc   = -1;
    done_cyc       = -1;
    zero_cyc       = (w == 0 || h == 0) ? cyc + 1 : -1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        a = base + 16'(r * w + c);
        addr_q.push_back(a);
        pix_q.push_back('{d: a[7:0], eol: (c == w - 1), eof: (c == w - 1) && (r == h - 1)});
      end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (!bus.busy && pix_q.size() == 0 && addr_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("frame_idle_in_time", i < max, 1);
  endtask

  task automatic run_frame(input logic [15:0] base, input int w, input int h, input int mode);
    ready_mode = mode;
    start_frame(base, w, h);
    wait_idle(500);
    if (mode == 0) begin
      chk("first_read_cycle", first_rd_cyc, start_cyc + 1);
      chk("done_cycle", done_cyc, start_cyc + 2 + w * h);
    end
    $display("frame base=%04h %0dx%0d mode=%0d done_cyc=%0d", base, w, h, mode, done_cyc);
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.base_addr = 0;
    bus.img_width = 0; bus.img_height = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.sram_rd_en, bus.sram_addr, bus.pix_data, bus.pix_eol, bus.pix_eof,
                          bus.pix_valid, bus.busy, bus.frame_done}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(16'h0100, 3, 2, 0);

    // Backpressure plus a start pulse while busy, which must be ignored
    ready_mode = 2;
    start_frame(16'h0A00, 4, 1);
    @(posedge clk); #1;
    bus.base_addr = 16'h5555; bus.img_width = 1; bus.img_height = 1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(200);
    $display("frame base=0a00 4x1 backpressure done_cyc=%0d", done_cyc);

    // Zero dimension
    ready_mode = 0;
    start_frame(16'h0040, 0, 5);
    chk("zero_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("zero_busy_later", bus.busy, 0);
    chk("zero_done_cycle", done_cyc, start_cyc + 1);
    $display("zero-dim start done_cyc=%0d", done_cyc);

    run_frame(16'hFFFE, 4, 1, 0);

    // Abort with both entries buffered, then immediate restart
    ready_mode = 3;
    start_frame(16'h2000, 5, 3);
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_prefill_valid", bus.pix_valid, 1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_valid", bus.pix_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.frame_done, 0);
    $display("abort issued, restarting");
    run_frame(16'h3000, 2, 2, 0);

    // Asynchronous reset mid-frame
    ready_mode = 1;
    start_frame(16'h0400, 6, 4);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("midframe_rst_outputs", {bus.sram_rd_en, bus.sram_addr, bus.pix_data, bus.pix_eol, bus.pix_eof,
                                 bus.pix_valid, bus.busy, bus.frame_done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("mid-frame reset applied");
    run_frame(16'h0800, 3, 3, 0);

    for (int i = 0; i < 10; i++)
      run_frame(16'($urandom), $urandom_range(1, 7), $urandom_range(1, 4), $urandom_range(0, 2));

    repeat (3) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
